// File: rtl/tea_pkg.sv
// Shared types and helpers for the TEA/XTEA block cipher engine.
// Holds the round constant, FSM states and byte-order helpers.
package tea_pkg;

  localparam logic [31:0] DELTA = 32'h9E3779B9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] sum;
  } blk_t;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] dec_sum(input int rounds);
    logic [31:0] r;
    r = 32'(rounds);
    return DELTA * r;
  endfunction

endpackage

// File: rtl/tea_if.sv
// Block handshake bundle between a host and the cipher engine.
// Input side carries the block and mode, output side the result.
interface tea_if;
  logic [63:0] in_data;
  logic        in_decrypt;
  logic        in_variant;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  modport master (
    output in_data, in_decrypt, in_variant, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  in_data, in_decrypt, in_variant, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/tea_round.sv
// One combinational TEA or XTEA cycle (Feistel pair), either direction.
// Decrypt paths undo the encrypt half-rounds in reverse order.
module tea_round
  import tea_pkg::*;
(
  input  logic [31:0]  v0,
  input  logic [31:0]  v1,
  input  logic [31:0]  sum,
  input  logic [127:0] key,
  input  logic         decrypt,
  input  logic         variant,
  output blk_t         nxt
);

  logic [31:0] k [4];
  logic [31:0] s_up, s_dn, a;

  assign k[0] = bswap32(key[127:96]);
  assign k[1] = bswap32(key[95:64]);
  assign k[2] = bswap32(key[63:32]);
  assign k[3] = bswap32(key[31:0]);
  assign s_up = sum + DELTA;
  assign s_dn = sum - DELTA;

  function automatic logic [31:0] tf(
    input logic [31:0] v, s, ka, kb
  );
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  function automatic logic [31:0] xf(input logic [31:0] v);
    return ((v << 4) ^ (v >> 5)) + v;
  endfunction

  always_comb begin
    a   = '0;
    nxt = '{v0: v0, v1: v1, sum: sum};
    unique case ({variant, decrypt})
      2'b00: begin
        a   = v0 + tf(v1, s_up, k[0], k[1]);
        nxt = '{v0: a,
                v1: v1 + tf(a, s_up, k[2], k[3]),
                sum: s_up};
      end
      2'b01: begin
        a   = v1 - tf(v0, sum, k[2], k[3]);
        nxt = '{v0: v0 - tf(a, sum, k[0], k[1]),
                v1: a,
                sum: s_dn};
      end
      2'b10: begin
        a   = v0 + (xf(v1) ^ (sum + k[sum[1:0]]));
        nxt = '{v0: a,
                v1: v1 + (xf(a) ^ (s_up + k[s_up[12:11]])),
                sum: s_up};
      end
      2'b11: begin
        a   = v1 - (xf(v0) ^ (sum + k[sum[12:11]]));
        nxt = '{v0: v0 - (xf(a) ^ (s_dn + k[s_dn[1:0]])),
                v1: a,
                sum: s_dn};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tea_engine.sv
// Iterative TEA/XTEA engine: one Feistel pair per clock, ROUNDS pairs
// per block, with a valid/ready handshake on both sides.
module tea_engine
  import tea_pkg::*;
#(
  parameter int ROUNDS  = 32,
  parameter bit XTEA_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] key,
  input  logic         key_we,
  tea_if.slave         bus
);

  localparam int CW = $clog2(ROUNDS + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   v0, v1, sum;
  logic [127:0]  key_r;
  logic          dec_r, var_r;
  logic          accept;
  blk_t          rnd;

  assign accept = bus.in_valid && bus.in_ready;

  tea_round u_round (
    .v0      (v0),
    .v1      (v1),
    .sum     (sum),
    .key     (key_r),
    .decrypt (dec_r),
    .variant (var_r),
    .nxt     (rnd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (cnt == CW'(1)) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE) && !key_we;
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
    bus.out_data  = {bswap32(v0), bswap32(v1)};
  end

  // Key only changes between blocks, so a running block never sees it move.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_r <= '0;
      v0    <= '0;
      v1    <= '0;
      sum   <= '0;
      cnt   <= '0;
      dec_r <= 1'b0;
      var_r <= 1'b0;
    end else begin
      if (state == IDLE && key_we) key_r <= key;
      if (accept) begin
        v0    <= bswap32(bus.in_data[63:32]);
        v1    <= bswap32(bus.in_data[31:0]);
        sum   <= bus.in_decrypt ? dec_sum(ROUNDS) : '0;
        cnt   <= CW'(ROUNDS);
        dec_r <= bus.in_decrypt;
        var_r <= XTEA_EN & bus.in_variant;
      end else if (state == RUN) begin
        v0  <= rnd.v0;
        v1  <= rnd.v1;
        sum <= rnd.sum;
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tea_engine.sv
// Directed bench for tea_engine at ROUNDS=32 and ROUNDS=8 with a
// reference cipher model feeding an expected-result queue.
module tb_tea_engine;

  localparam logic [31:0] DLT = 32'h9E3779B9;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] key;
  logic         key_we;
  logic [63:0]  in_data;
  logic         in_decrypt, in_variant, in_valid, out_ready;
  logic         in_ready, out_valid, busy;
  logic [63:0]  out_data;
  logic         sel;

  int nassert = 0;
  int nfail   = 0;
  logic [63:0] sb[$];

  tea_if b32 ();
  tea_if b8 ();

  assign b32.in_data    = in_data;
  assign b32.in_decrypt = in_decrypt;
  assign b32.in_variant = in_variant;
  assign b32.in_valid   = in_valid & ~sel;
  assign b32.out_ready  = out_ready & ~sel;
  assign b8.in_data     = in_data;
  assign b8.in_decrypt  = in_decrypt;
  assign b8.in_variant  = in_variant;
  assign b8.in_valid    = in_valid & sel;
  assign b8.out_ready   = out_ready & sel;

  assign in_ready  = sel ? b8.in_ready  : b32.in_ready;
  assign out_valid = sel ? b8.out_valid : b32.out_valid;
  assign busy      = sel ? b8.busy      : b32.busy;
  assign out_data  = sel ? b8.out_data  : b32.out_data;

  tea_engine #(.ROUNDS(32), .XTEA_EN(1'b1)) dut32 (
    .clk     (clk),
    .reset_n (reset_n),
    .key     (key),
    .key_we  (key_we),
    .bus     (b32)
  );

  tea_engine #(.ROUNDS(8), .XTEA_EN(1'b1)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .key     (key),
    .key_we  (key_we),
    .bus     (b8)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bsw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [63:0] model(
    input logic [127:0] k, input logic [63:0] d,
    input bit dec, input bit x, input int n
  );
    logic [31:0] v0, v1, s;
    logic [31:0] kk [4];
    v0 = bsw(d[63:32]);
    v1 = bsw(d[31:0]);
    kk[0] = bsw(k[127:96]);
    kk[1] = bsw(k[95:64]);
    kk[2] = bsw(k[63:32]);
    kk[3] = bsw(k[31:0]);
    s = 32'h0;
    if (dec) repeat (n) s = s + DLT;
    for (int i = 0; i < n; i++) begin
      if (!x && !dec) begin
        s  = s + DLT;
        v0 = v0 + (((v1 << 4) + kk[0]) ^ (v1 + s) ^ ((v1 >> 5) + kk[1]));
        v1 = v1 + (((v0 << 4) + kk[2]) ^ (v0 + s) ^ ((v0 >> 5) + kk[3]));
      end else if (!x) begin
        v1 = v1 - (((v0 << 4) + kk[2]) ^ (v0 + s) ^ ((v0 >> 5) + kk[3]));
        v0 = v0 - (((v1 << 4) + kk[0]) ^ (v1 + s) ^ ((v1 >> 5) + kk[1]));
        s  = s - DLT;
      end else if (!dec) begin
        v0 = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + kk[s[1:0]]));
        s  = s + DLT;
        v1 = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + kk[s[12:11]]));
      end else begin
        v1 = v1 - ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + kk[s[12:11]]));
        s  = s - DLT;
        v0 = v0 - ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + kk[s[1:0]]));
      end
    end
    return {bsw(v0), bsw(v1)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_key(input logic [127:0] k);
    @(negedge clk);
    key    = k;
    key_we = 1'b1;
    #1 chk("ready_low_on_key_we", 64'(in_ready), 64'd0);
    @(negedge clk);
    key_we = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input bit dec,
                      input bit x, input logic [63:0] e);
    @(negedge clk);
    in_data    = d;
    in_decrypt = dec;
    in_variant = x;
    in_valid   = 1'b1;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic recv(input int stall, input int kpulse,
                      output logic [63:0] res);
    int lat;
    logic [63:0] held, e;
    lat = 0;
    while (!out_valid && lat < 300) begin
      if (lat == kpulse) begin
        key    = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        key_we = 1'b1;
      end
      @(posedge clk);
      #1 key_we = 1'b0;
      lat++;
    end
    chk("latency", 64'(lat), sel ? 64'd8 : 64'd32);
    held = out_data;
    repeat (stall) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", out_data, held);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    chk("result", out_data, e);
    res = out_data;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("valid_drop", 64'(out_valid), 64'd0);
  endtask

  localparam logic [127:0] K1 = 128'h2b02056806144976775d0e266c287843;
  localparam logic [127:0] KX = 128'h4d763217053f752c5d0416361572632f;
  localparam logic [127:0] K3 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [63:0]  P1 = 64'h74657374206d652e;
  localparam logic [63:0]  C1 = 64'h775d2a6af6ce9209;

  initial begin
    logic [63:0] r, c, x;
    reset_n = 1'b0;
    key = '0; key_we = 1'b0;
    in_data = '0; in_decrypt = 1'b0; in_variant = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    send(64'h0, 1'b0, 1'b0, 64'h0a3aea4140a9ba94);
    recv(0, -1, r);

    write_key(K1);
    send(P1, 1'b0, 1'b0, C1);
    recv(0, -1, r);
    send(C1, 1'b1, 1'b0, P1);
    recv(0, -1, r);

    write_key(KX);
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int i = 0; i < 4; i++) begin
        x = {$urandom, $urandom};
        send(x, 1'b0, 1'b1, model(KX, x, 1'b0, 1'b1, sel ? 8 : 32));
        recv(0, -1, c);
        nassert++;
        assert (c !== x) else begin
          nfail++;
          $error("FAIL ct_ne_pt: observed %h expected not %h", c, x);
        end
        send(c, 1'b1, 1'b1, x);
        recv(0, -1, r);
      end
    end
    x = 64'h0123456789abcdef;
    send(x, 1'b0, 1'b0, model(KX, x, 1'b0, 1'b0, 8));
    recv(0, -1, c);
    sel = 1'b0;

    write_key(K1);
    send(P1, 1'b0, 1'b0, C1);
    recv(10, 5, r);
    send(P1, 1'b0, 1'b0, C1);
    recv(0, -1, r);

    send(P1, 1'b0, 1'b0, C1);
    repeat (15) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    reset_n = 1'b1;
    send(P1, 1'b0, 1'b0, model(128'h0, P1, 1'b0, 1'b0, 32));
    recv(0, -1, r);

    @(negedge clk);
    key      = K3;
    key_we   = 1'b1;
    in_data  = P1;
    in_decrypt = 1'b0;
    in_variant = 1'b0;
    in_valid = 1'b1;
    #1 chk("same_cycle_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("same_cycle_no_accept", 64'(busy), 64'd0);
    key_we = 1'b0;
    #1 chk("next_cycle_ready", 64'(in_ready), 64'd1);
    sb.push_back(model(K3, P1, 1'b0, 1'b0, 32));
    @(posedge clk);
    #1 in_valid = 1'b0;
    recv(0, -1, r);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule

// File: doc/tea_engine.md
TEA_ENGINE -- requirements
Module: tea_engine

Interface
REQ-001 Parameter ROUNDS, default 32, legal range 1..64: number of TEA/XTEA cycles (Feistel pairs) per block.
REQ-002 Parameter XTEA_EN, default 1: 1 = variant input honoured; 0 = core is TEA-only and variant is ignored.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 key  in  128  key value; sampled only on a key-write edge.
REQ-006 key_we  in  1  key write strobe.
REQ-007 in_data  in  64  plaintext or ciphertext block.
REQ-008 in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled at accept.
REQ-009 in_variant  in  1  0 = TEA, 1 = XTEA; sampled at accept.
REQ-010 in_valid / in_ready  in / out  1 each  input handshake.
REQ-011 out_data  out  64  result block.
REQ-012 out_valid / out_ready  out / in  1 each  output handshake.
REQ-013 busy  out  1  high in RUN and DONE.

Function
REQ-014 Byte order: v0 = bswap32(in_data[63:32]), v1 = bswap32(in_data[31:0]), k0..k3 = bswap32 of key[127:96]..key[31:0]; out_data is the same mapping applied in reverse.
REQ-015 DELTA = 0x9E3779B9; all arithmetic is modulo 2^32; shifts are logical (<<4, >>5).
REQ-016 TEA encrypt round: sum += DELTA; v0 += ((v1<<4)+k0)^(v1+sum)^((v1>>5)+k1); v1 += ((v0<<4)+k2)^(v0+sum)^((v0>>5)+k3).
REQ-017 TEA decrypt round: exact inverse of REQ-016 (v1 first, then v0, then sum -= DELTA), with initial sum = DELTA*ROUNDS mod 2^32.
REQ-018 XTEA encrypt round: v0 += (((v1<<4)^(v1>>5))+v1)^(sum+k[sum&3]); sum += DELTA; v1 += (((v0<<4)^(v0>>5))+v0)^(sum+k[(sum>>11)&3]).
REQ-019 XTEA decrypt round: exact inverse of REQ-018, with initial sum = DELTA*ROUNDS mod 2^32.
REQ-020 Encrypt initial sum = 0 for both variants.
REQ-021 The FSM has three states: IDLE, RUN and DONE.
REQ-022 in_ready = (state == IDLE) && !key_we.
REQ-023 Accept occurs on an edge where in_valid && in_ready: load v0/v1, sum, mode and variant; set round counter = ROUNDS; go to RUN.
REQ-024 RUN: exactly one round per clock; the counter decrements each edge; on the edge where the counter reaches 0, go to DONE.
REQ-025 Latency: out_valid rises exactly ROUNDS edges after the accept edge.
REQ-026 DONE: out_valid = 1 and out_data is held stable; on out_valid && out_ready, go to IDLE.
REQ-027 Back-to-back: the next block may be accepted on the edge after the DONE->IDLE edge.
REQ-028 key_we in IDLE writes the key register; key_we in RUN or DONE is ignored, and the key in use stays unchanged.
REQ-029 key_we and in_valid asserted together in IDLE: the key is written and the block is not accepted (in_ready = 0).
REQ-030 in_valid asserted outside IDLE has no effect.
REQ-031 out_data outside DONE is don't-care but SHALL NOT be X after reset.

Reset
REQ-032 reset_n low: asynchronously force state = IDLE, out_valid = 0, busy = 0, in_ready = 1, key register = 0, counter = 0, data registers = 0.
REQ-033 A reset asserted mid-RUN or in DONE discards the block; the first post-reset edge is IDLE.

Structure
REQ-034 Package tea_pkg holds: DELTA, the state enum, the bswap32 function, and a function computing the decrypt initial sum from ROUNDS.
REQ-035 Sub-module tea_round is combinational: {v0, v1, sum, key, decrypt, variant} -> {v0', v1', sum'}; it is instantiated once.
REQ-036 The round counter width is $clog2(ROUNDS+1).

Verification
REQ-037 TEA, ROUNDS=32, key 0, in_data 0, encrypt -> out_data 64'h0a3aea4140a9ba94, with out_valid exactly 32 edges after accept and not earlier.
REQ-038 TEA, key 128'h2b02056806144976775d0e266c287843, in_data 64'h74657374206d652e -> 64'h775d2a6af6ce9209; decrypting that result returns the plaintext.
REQ-039 XTEA round trip with key 128'h4d763217053f752c5d0416361572632f over 4 blocks at ROUNDS=32 and ROUNDS=8: dec(enc(x)) == x, and ciphertext != plaintext.
REQ-040 out_ready held low 10 cycles in DONE -> out_valid and out_data stable, in_ready = 0; key_we pulsed during RUN -> result unchanged.
REQ-041 reset_n pulsed low at round 15 -> out_valid = 0 immediately; the next accepted block yields the correct result using key 0.
REQ-042 key_we and in_valid asserted on the same IDLE cycle -> no accept; the following cycle accepts the block with the new key.
